// File: rtl/async_fifo_write_arbiter.sv
// Round-robin arbiter sharing the async_fifo write port among NUM_REQ write-domain requesters.
// A grant is held for up to BURST_MAX beats so each source's bursts land contiguously.
module async_fifo_write_arbiter #(
   parameter int unsigned BITS      = 32,
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned BURST_MAX = 4,
   localparam int unsigned GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    write_clk,
   input  logic                    write_rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    p_write_full,
   output logic                    p_write_en,
   output logic [BITS-1:0]         p_write_data,
   output logic                    grant_valid,
   output logic [GID_W-1:0]        grant_id
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e           state;
   logic [7:0]       burst_cnt;
   logic [GID_W-1:0] rr_ptr;

   logic             holder_valid;
   logic             last_beat;
   logic             release_grant;
   logic [GID_W-1:0] next_start;
   logic [GID_W:0]   sel_rr;
   logic [GID_W:0]   sel_nx;

   // Returns {found, index} of the first valid requester searching cyclically from start.
   function automatic logic [GID_W:0] sel(input logic [GID_W-1:0] start,
                                          input logic [NUM_REQ-1:0] valid);
      logic             found;
      logic [GID_W-1:0] idx;
      int               j;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         j = (int'(start) + k) % int'(NUM_REQ);
         if (!found && valid[j]) begin
            found = 1'b1;
            idx   = GID_W'(j);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      holder_valid  = req_valid[grant_id];
      next_start    = (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      sel_rr        = sel(rr_ptr, req_valid);
      sel_nx        = sel(next_start, req_valid);
      last_beat     = p_write_en && (burst_cnt == 8'(BURST_MAX - 1));
      release_grant = !holder_valid || last_beat;
   end

   always_comb begin
      req_ready = '0;
      if (grant_valid && !p_write_full) begin
         req_ready[grant_id] = 1'b1;
      end
      p_write_en   = grant_valid && holder_valid && !p_write_full;
      p_write_data = grant_valid ? req_data[int'(grant_id)*BITS +: BITS] : '0;
   end

   always_ff @(posedge write_clk or negedge write_rst_n) begin
      if (!write_rst_n) begin
         state       <= StIdle;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         burst_cnt   <= '0;
         rr_ptr      <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (sel_rr[GID_W]) begin
                  grant_id    <= sel_rr[GID_W-1:0];
                  grant_valid <= 1'b1;
                  burst_cnt   <= '0;
                  state       <= StGrant;
               end
            end
            StGrant: begin
               // Handoff is evaluated on this cycle's req_valid, so there is no idle bubble.
               if (release_grant) begin
                  rr_ptr    <= next_start;
                  burst_cnt <= '0;
                  if (sel_nx[GID_W]) begin
                     grant_id <= sel_nx[GID_W-1:0];
                  end else begin
                     grant_id    <= '0;
                     grant_valid <= 1'b0;
                     state       <= StIdle;
                  end
               end else if (p_write_en) begin
                  burst_cnt <= burst_cnt + 8'd1;
               end
            end
            default: begin
               state       <= StIdle;
               grant_valid <= 1'b0;
               grant_id    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
// Directed bench for async_fifo_write_arbiter: per-requester source queues, a FIFO occupancy
// model for the full flag, and a write log compared against hand-derived sequences.
module tb_async_fifo_write_arbiter;

   localparam int BITS    = 32;
   localparam int NUM_REQ = 4;
   localparam int QD      = 64;

   logic                    write_clk = 1'b0;
   logic                    write_rst_n;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*BITS-1:0] req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    p_write_full;
   logic                    p_write_en;
   logic [BITS-1:0]         p_write_data;
   logic                    grant_valid;
   logic [1:0]              grant_id;

   async_fifo_write_arbiter #(
      .BITS      (BITS),
      .NUM_REQ   (NUM_REQ),
      .BURST_MAX (4)
   ) dut (
      .write_clk    (write_clk),
      .write_rst_n  (write_rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .p_write_full (p_write_full),
      .p_write_en   (p_write_en),
      .p_write_data (p_write_data),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id)
   );

   always #5 write_clk = ~write_clk;

   logic [31:0] qmem [NUM_REQ][QD];
   int          qh [NUM_REQ];
   int          qt [NUM_REQ];
   logic [31:0] wlog [$];
   logic        gv_hist  [256];
   logic [1:0]  gid_hist [256];
   logic        wen_hist [256];
   int          cyc;
   int          occ;
   logic        occ_en;
   logic        rd_en;
   logic        rnd_full;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]              = (qh[i] != qt[i]);
         req_data[i*BITS +: BITS]  = qmem[i][qh[i] % QD];
      end
      p_write_full = (occ_en && occ >= 16) || rnd_full;
   endtask

   task automatic push(input int i, input logic [31:0] d);
      qmem[i][qt[i] % QD] = d;
      qt[i]++;
   endtask

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < NUM_REQ; i++) n += qt[i] - qh[i];
      return n;
   endfunction

   // Observe at the negedge, then retire accepted beats just after the posedge.
   task automatic cycle();
      logic [NUM_REQ-1:0] acc;
      @(negedge write_clk);
      acc = req_valid & req_ready;
      if (cyc < 256) begin
         gv_hist[cyc]  = grant_valid;
         gid_hist[cyc] = grant_id;
         wen_hist[cyc] = p_write_en;
      end
      if (p_write_full) check("no_write_while_full", {31'd0, p_write_en}, 32'd0);
      if (p_write_en) begin
         wlog.push_back(p_write_data);
         occ++;
      end
      if (rd_en && occ > 0) occ--;
      @(posedge write_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) qh[i]++;
      cyc++;
      drive();
   endtask

   task automatic run_until_empty(input int max_cycles);
      for (int n = 0; n < max_cycles; n++) begin
         cycle();
         if (pending() == 0) break;
      end
      check("drain_timeout", pending(), 32'd0);
   endtask

   task automatic do_reset();
      write_rst_n = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         qh[i] = 0;
         qt[i] = 0;
      end
      wlog.delete();
      occ = 0; occ_en = 1'b0; rd_en = 1'b0; rnd_full = 1'b0;
      drive();
      repeat (2) @(posedge write_clk);
      #1;
      write_rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_q [$];
      int          cnt;
      int          seed_val;
      int          exp_seq [NUM_REQ];
      int          pushed;

      // Reset state
      do_reset();
      #1;
      check("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
      check("rst_grant_id", {30'd0, grant_id}, 32'd0);
      check("rst_write_en", {31'd0, p_write_en}, 32'd0);
      check("rst_req_ready", {28'd0, req_ready}, 32'd0);
      check("rst_write_data", p_write_data, 32'd0);

      // Single requester: 1-cycle latency, no bubble across re-grants
      do_reset();
      for (int k = 0; k < 10; k++) push(0, 32'h100 + k);
      drive();
      run_until_empty(40);
      cycle();
      cycle();
      check("single_lat_idle", {31'd0, wen_hist[0]}, 32'd0);
      cnt = 0;
      for (int k = 1; k <= 10; k++) cnt += int'(wen_hist[k]);
      check("single_contiguous", cnt, 32'd10);
      check("single_after_last", {31'd0, wen_hist[11]}, 32'd0);
      check("single_count", wlog.size(), 32'd10);
      for (int k = 0; k < 10; k++) check("single_data", wlog[k], 32'h100 + k);
      check("single_idle_after", {31'd0, gv_hist[12]}, 32'd0);

      // Round-robin: all four busy, four beats per grant in index order
      do_reset();
      for (int i = 0; i < NUM_REQ; i++)
         for (int s = 0; s < 8; s++) push(i, (i << 8) | s);
      drive();
      run_until_empty(80);
      exp_q.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NUM_REQ; i++)
            for (int s = 0; s < 4; s++) exp_q.push_back((i << 8) | (r * 4 + s));
      check("rr_count", wlog.size(), 32'd32);
      for (int k = 0; k < 32; k++) check("rr_data", wlog[k], exp_q[k]);
      cnt = 0;
      for (int k = 1; k <= 32; k++) cnt += int'(wen_hist[k]);
      check("rr_contiguous", cnt, 32'd32);

      // Full back-pressure: FIFO has 2 entries, fills mid-burst of requester 3
      do_reset();
      occ = 2;
      occ_en = 1'b1;
      for (int s = 0; s < 12; s++) begin
         push(1, 32'h100 + s);
         push(3, 32'h300 + s);
      end
      drive();
      repeat (20) cycle();
      #1;
      check("full_flag", {31'd0, p_write_full}, 32'd1);
      check("full_writes", wlog.size(), 32'd14);
      check("full_write_en", {31'd0, p_write_en}, 32'd0);
      check("full_req_ready", {28'd0, req_ready}, 32'd0);
      check("full_grant_valid", {31'd0, grant_valid}, 32'd1);
      check("full_grant_id", {30'd0, grant_id}, 32'd3);
      rd_en = 1'b1;
      run_until_empty(200);
      exp_q.delete();
      for (int r = 0; r < 3; r++)
         for (int id = 1; id <= 3; id += 2)
            for (int s = 0; s < 4; s++) exp_q.push_back((id << 8) | (r * 4 + s));
      check("full_total", wlog.size(), 32'd24);
      for (int k = 0; k < 24; k++) check("full_data", wlog[k], exp_q[k]);

      // Early release: requester 1 idles after 2 beats, requester 2 takes over
      do_reset();
      push(1, 32'h110);
      push(1, 32'h111);
      for (int s = 0; s < 4; s++) push(2, 32'h220 + s);
      drive();
      repeat (4) cycle();
      push(1, 32'h112);
      drive();
      run_until_empty(40);
      check("early_hold_gv", {31'd0, gv_hist[3]}, 32'd1);
      check("early_hold_gid", {30'd0, gid_hist[3]}, 32'd1);
      check("early_no_beat", {31'd0, wen_hist[3]}, 32'd0);
      check("early_next_gid", {30'd0, gid_hist[4]}, 32'd2);
      check("early_next_beat", {31'd0, wen_hist[4]}, 32'd1);
      exp_q = '{32'h110, 32'h111, 32'h220, 32'h221, 32'h222, 32'h223, 32'h112};
      check("early_count", wlog.size(), 32'd7);
      for (int k = 0; k < 7; k++) check("early_data", wlog[k], exp_q[k]);

      // Reset mid-burst: requester 2 with two beats done
      do_reset();
      for (int s = 0; s < 8; s++) push(2, 32'h200 + s);
      drive();
      repeat (3) cycle();
      check("midrst_pre_gid", {30'd0, grant_id}, 32'd2);
      write_rst_n = 1'b0;
      #1;
      check("midrst_grant_valid", {31'd0, grant_valid}, 32'd0);
      check("midrst_grant_id", {30'd0, grant_id}, 32'd0);
      check("midrst_write_en", {31'd0, p_write_en}, 32'd0);
      check("midrst_req_ready", {28'd0, req_ready}, 32'd0);
      push(1, 32'h150);
      drive();
      @(posedge write_clk);
      #1;
      write_rst_n = 1'b1;
      cyc = 0;
      repeat (3) cycle();
      check("midrst_first_gid", {30'd0, gid_hist[1]}, 32'd1);
      check("midrst_first_beat", {31'd0, wen_hist[1]}, 32'd1);
      check("midrst_first_data", wlog[2], 32'h150);

      // Random soak: per-requester order with random full
      do_reset();
      seed_val = $urandom(7);
      pushed = 0;
      for (int i = 0; i < NUM_REQ; i++) exp_seq[i] = 0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ($urandom_range(0, 3) == 0 && (qt[i] - qh[i]) < 8) begin
               push(i, (i << 8) | (qt[i] & 8'hff));
               pushed++;
            end
         end
         rnd_full = ($urandom_range(0, 3) == 0);
         drive();
         cycle();
      end
      rnd_full = 1'b0;
      drive();
      run_until_empty(300);
      check("soak_total", wlog.size(), pushed);
      foreach (wlog[k]) begin
         check("soak_order", {24'd0, wlog[k][7:0]}, exp_seq[wlog[k][9:8]] & 32'hff);
         exp_seq[wlog[k][9:8]]++;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/async_fifo_write_arbiter.md
Name: async_fifo_write_arbiter

Overview:
- Round-robin arbiter sharing the single write port of async_fifo among NUM_REQ requesters in the write_clk domain.
- Grants one requester at a time and holds the grant for up to BURST_MAX beats, so bursts from one source stay contiguous in the FIFO.
- Drives p_write_en/p_write_data directly into async_fifo and back-pressures requesters from p_write_full.

Parameters:
- BITS, 32, width of each FIFO entry; must equal async_fifo BITS.
- NUM_REQ, 4, number of requesters (2..16).
- BURST_MAX, 4, maximum beats per grant before forced rotation (1..255).
- GID_W, $clog2(NUM_REQ) with minimum 1, width of grant_id (derived, not overridden).

Ports:
- write_clk  in  1  write-domain clock, shared with async_fifo write side.
- write_rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester valid; requester i is bit i.
- req_data  in  NUM_REQ*BITS  packed data; requester i at [i*BITS +: BITS].
- req_ready  out  NUM_REQ  per-requester accept; a beat transfers when req_valid[i] & req_ready[i].
- p_write_full  in  1  FIFO full flag from async_fifo.
- p_write_en  out  1  FIFO write enable.
- p_write_data  out  BITS  FIFO write data.
- grant_valid  out  1  a requester currently holds the grant.
- grant_id  out  GID_W  index of the current grant holder; 0 when grant_valid=0.

Behaviour:
- Reset (async, write_rst_n=0): state=IDLE, grant_valid=0, grant_id=0, burst_cnt=0, rr_ptr=0. req_ready=0, p_write_en=0, p_write_data=0 (combinational from the cleared state).
- Reset mid-burst drops the grant immediately. Beats already written stay in the FIFO. No partial beat is issued.
- Both FSM state and grant are registered. Outputs are combinational from registered grant plus inputs:
  - req_ready[i] = grant_valid & (grant_id==i) & ~p_write_full.
  - p_write_en = grant_valid & req_valid[grant_id] & ~p_write_full.
  - p_write_data = req_data[grant_id]. It is muxed whenever grant_valid=1, else 0.
- Selection function SEL(start): lowest index j, searching cyclically from start, with req_valid[j]=1. It returns none if no req_valid is set.
- IDLE:
  - If any req_valid is set: load grant_id=SEL(rr_ptr), grant_valid=1, burst_cnt=0, go to GRANT.
  - Arbitration latency is 1 cycle: req_valid seen at edge t, first possible write at edge t+1.
- GRANT, with g = grant_id:
  - Beat (p_write_en=1): burst_cnt += 1.
  - Release condition A: req_valid[g]=0 (requester idle). No beat this cycle.
  - Release condition B: a beat occurs with burst_cnt==BURST_MAX-1.
  - On release: rr_ptr=(g+1) mod NUM_REQ. Next grant = SEL((g+1) mod NUM_REQ), evaluated on the current cycle's req_valid.
  - If a next grant exists, load it with burst_cnt=0 and stay in GRANT. This is a zero-bubble handoff, and g itself may be re-selected if it is the only requester.
  - If no next grant exists, go to IDLE with grant_valid=0.
  - p_write_full=1: no beat, burst_cnt frozen, grant held. Full never causes rotation. Condition A still applies if the holder drops req_valid.
- No beat is ever written when p_write_full=1, so async_fifo overflow is impossible from this block.
- Per-requester ordering is preserved. Beats from one requester are never reordered.
- Fairness: with all NUM_REQ requesting continuously and FIFO never full, each requester receives exactly BURST_MAX beats per rotation, in index order from rr_ptr.
- Requesters must hold req_valid and req_data stable until accepted. The arbiter does not check this.

Test Plan:
- Reset: assert write_rst_n=0 mid-burst (requester 2, burst_cnt=2) -> grant_valid=0, grant_id=0, p_write_en=0, req_ready=4'b0000 immediately. After release, first grant goes to the lowest active index from 0.
- Single requester: req_valid=4'b0001, 10 beats 0x100..0x109, FIFO not full -> first p_write_en 1 cycle after req_valid. Grant re-selects 0 every 4 beats with no bubble. FIFO read side returns 0x100..0x109 in order.
- Round-robin: all 4 requesters valid continuously, data = (id<<8)|seq, BURST_MAX=4 -> FIFO sequence is 0x000-0x003, 0x100-0x103, 0x200-0x203, 0x300-0x303, 0x004-... The scoreboard confirms per-id order and exactly 4 beats per grant.
- Full back-pressure: SIZE=16, reads disabled, requesters 1 and 3 valid -> exactly 16 writes accepted, then p_write_full=1 holds p_write_en=0 and req_ready=0 with grant unchanged. Enabling reads resumes writes with burst_cnt continuing from its frozen value.
- Early release: requester 1 drops req_valid after 2 beats while requester 2 is valid -> the next cycle grant_id=2 with no idle cycle, and requester 1 is not regranted before requester 2.
- Random soak: seed 7, random req_valid/data over 5000 cycles with randomly gated reads under both clock ratios -> zero data mismatches, no write while full, no requester waits more than (NUM_REQ-1)*BURST_MAX beats while the FIFO is not full.
